video_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 sync generator: produces hsync/vsync, display enable, frame/line strobes, pixel coordinates and a linear framebuffer read address for any raster timing.
- Adds a pixel-clock enable, per-signal sync polarity, pixel/line replication (scaled framebuffers), and a configurable pipeline lag so the sync/enable outputs align with a LAG-cycle framebuffer read.
- Sits between the framebuffer RAM and the VGA pins.

---
 rtl/video_timing_gen_pkg.sv | 57 +++++
 rtl/video_delay_line.sv | 27 ++
 rtl/video_timing_gen.sv | 152 +++++++++++++++
 tb/tb_video_timing_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/video_timing_gen_pkg.sv
// Shared raster constants, stage-0 control bus type and timing derivation helpers
// for video_timing_gen.
package video_timing_gen_pkg;

    // 640x480@60 (25.175 MHz pixel clock)
    localparam int unsigned VGA_H_DISPLAY = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_V_DISPLAY = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;

    // 800x600@60 (40 MHz pixel clock)
    localparam int unsigned SVGA_H_DISPLAY = 800;
    localparam int unsigned SVGA_H_FRONT   = 40;
    localparam int unsigned SVGA_H_SYNC    = 128;
    localparam int unsigned SVGA_H_BACK    = 88;
    localparam int unsigned SVGA_V_DISPLAY = 600;
    localparam int unsigned SVGA_V_FRONT   = 1;
    localparam int unsigned SVGA_V_SYNC    = 4;
    localparam int unsigned SVGA_V_BACK    = 23;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic display_on;
        logic line_start;
        logic frame_start;
    } vt_ctrl_t;

    function automatic int unsigned timing_total(input int unsigned display,
                                                 input int unsigned front,
                                                 input int unsigned sync,
                                                 input int unsigned back);
        return display + front + sync + back;
    endfunction

    function automatic int unsigned sync_first(input int unsigned display,
                                               input int unsigned front);
        return display + front;
    endfunction

    function automatic int unsigned sync_last(input int unsigned display,
                                              input int unsigned front,
                                              input int unsigned sync);
        return display + front + sync - 1;
    endfunction

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result = 0;
        while ((64'(1) << result) < 64'(value)) result++;
        return result;
    endfunction

endpackage

// File: rtl/video_delay_line.sv
// Pixel-enable qualified shift register; every stage clears asynchronously to RST_VAL.
module video_delay_line #(
    parameter int unsigned    W       = 8,
    parameter int unsigned    LAG     = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_ce,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_stage [LAG];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < LAG; i++) r_stage[i] <= RST_VAL;
        end else if (i_ce) begin
            r_stage[0] <= i_d;
            for (int unsigned i = 1; i < LAG; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[LAG-1];

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: stage-0 counters and framebuffer address, with
// sync/enable/position delayed LAG pixel enables to line up with the framebuffer read.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
    parameter int unsigned V_FRONT   = VGA_V_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0,
    parameter int unsigned X_SHIFT   = 0,
    parameter int unsigned Y_SHIFT   = 0,
    parameter int unsigned LAG       = 1,
    parameter int unsigned ADDR_W    = 19,
    localparam int unsigned HW = clog2(timing_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK)),
    localparam int unsigned VW = clog2(timing_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK))
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_pix_ce,
    output logic [ADDR_W-1:0] o_display_addr,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_display_on,
    output logic [HW-1:0]     o_hpos,
    output logic [VW-1:0]     o_vpos,
    output logic              o_line_start,
    output logic              o_frame_start
);

    localparam int unsigned H_TOTAL = timing_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = timing_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT     = HW'(H_DISPLAY);
    localparam logic [VW-1:0] V_ACT     = VW'(V_DISPLAY);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_DISPLAY - 1);
    localparam logic [HW-1:0] HS_FIRST  = HW'(sync_first(H_DISPLAY, H_FRONT));
    localparam logic [HW-1:0] HS_LAST   = HW'(sync_last(H_DISPLAY, H_FRONT, H_SYNC));
    localparam logic [VW-1:0] VS_FIRST  = VW'(sync_first(V_DISPLAY, V_FRONT));
    localparam logic [VW-1:0] VS_LAST   = VW'(sync_last(V_DISPLAY, V_FRONT, V_SYNC));
    localparam logic [HW-1:0] X_MASK    = HW'((1 << X_SHIFT) - 1);
    localparam logic [VW-1:0] Y_MASK    = VW'((1 << Y_SHIFT) - 1);
    localparam longint unsigned LAST_ADDR =
        longint'(H_DISPLAY >> X_SHIFT) * longint'(V_DISPLAY >> Y_SHIFT) - 1;
    localparam int unsigned DL_W = $bits(vt_ctrl_t) + HW + VW;
    localparam logic [DL_W-1:0] DL_RST = {~HSYNC_POL, ~VSYNC_POL, 3'b000, HW'(0), VW'(0)};

    if (H_DISPLAY % (1 << X_SHIFT) != 0 || V_DISPLAY % (1 << Y_SHIFT) != 0) begin : g_bad_scale
        $error("display size is not a multiple of the replication factor");
    end
    if (H_DISPLAY < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_DISPLAY < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_timing
        $error("every timing parameter must be at least 1");
    end
    if (LAG < 1 || LAG > 4) begin : g_bad_lag
        $error("LAG must be in 1..4");
    end
    if ((LAST_ADDR >> ADDR_W) != 0) begin : g_bad_addr_w
        $error("ADDR_W too narrow for the last framebuffer address");
    end

    logic [HW-1:0]     r_hc;
    logic [VW-1:0]     r_vc;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_line_base;
    logic              r_ce;
    logic              w_h_wrap;
    logic              w_v_wrap;
    vt_ctrl_t          w_ctrl0;
    vt_ctrl_t          w_ctrl_q;
    logic [DL_W-1:0]   w_dl_q;

    assign w_h_wrap = (r_hc == H_LAST);
    assign w_v_wrap = (r_vc == V_LAST);

    // Reset parks the counters on the last raster position so the first enable lands on (0,0).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hc <= H_LAST;
            r_vc <= V_LAST;
        end else if (i_pix_ce) begin
            if (w_h_wrap) begin
                r_hc <= '0;
                r_vc <= w_v_wrap ? '0 : r_vc + VW'(1);
            end else begin
                r_hc <= r_hc + HW'(1);
            end
        end
    end

    // Stepping off the last active pixel leaves addr at the next source line's base.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr      <= '0;
            r_line_base <= '0;
        end else if (i_pix_ce) begin
            if (w_h_wrap) begin
                if (w_v_wrap) begin
                    r_addr      <= '0;
                    r_line_base <= '0;
                end else if (r_vc < V_ACT_END) begin
                    if ((r_vc & Y_MASK) == Y_MASK) r_line_base <= r_addr;
                    else                           r_addr      <= r_line_base;
                end
            end else if (r_vc < V_ACT && r_hc < H_ACT && (r_hc & X_MASK) == X_MASK) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        w_ctrl0             = '0;
        w_ctrl0.hsync       = (r_hc >= HS_FIRST && r_hc <= HS_LAST) ? HSYNC_POL : ~HSYNC_POL;
        w_ctrl0.vsync       = (r_vc >= VS_FIRST && r_vc <= VS_LAST) ? VSYNC_POL : ~VSYNC_POL;
        w_ctrl0.display_on  = (r_hc < H_ACT) && (r_vc < V_ACT);
        w_ctrl0.line_start  = (r_hc == '0);
        w_ctrl0.frame_start = (r_hc == '0) && (r_vc == '0);
    end

    video_delay_line #(
        .W       (DL_W),
        .LAG     (LAG),
        .RST_VAL (DL_RST)
    ) u_delay (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ce    (i_pix_ce),
        .i_d     ({w_ctrl0, r_hc, r_vc}),
        .o_q     (w_dl_q)
    );

    // Strobes show only in the clk right after the enable that loaded them.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_ce <= 1'b0;
        else         r_ce <= i_pix_ce;
    end

    assign {w_ctrl_q, o_hpos, o_vpos} = w_dl_q;
    assign o_hsync        = w_ctrl_q.hsync;
    assign o_vsync        = w_ctrl_q.vsync;
    assign o_display_on   = w_ctrl_q.display_on;
    assign o_line_start   = w_ctrl_q.line_start & r_ce;
    assign o_frame_start  = w_ctrl_q.frame_start & r_ce;
    assign o_display_addr = r_addr;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 line timing and mid-line reset, plus a 16x8 raster with
// 2x replication / LAG=2 / positive syncs, and the same raster with a half-rate pixel enable.
module tb_video_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic ce_one = 1'b1;
    logic ce_s1;
    logic ce_s2;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // Default 640x480, LAG=1
    logic [18:0] d_addr;
    logic        d_hs, d_vs, d_den, d_ls, d_fs;
    logic [9:0]  d_hpos, d_vpos;

    video_timing_gen u_def (
        .i_clk (clk), .i_reset (reset), .i_pix_ce (ce_one), .o_display_addr (d_addr),
        .o_hsync (d_hs), .o_vsync (d_vs), .o_display_on (d_den), .o_hpos (d_hpos),
        .o_vpos (d_vpos), .o_line_start (d_ls), .o_frame_start (d_fs)
    );

    // 16x8 raster: active 8x4, hsync hpos 10..12, vsync lines 5..6
    logic [3:0] a_addr;
    logic       a_hs, a_vs, a_den, a_ls, a_fs;
    logic [3:0] a_hpos;
    logic [2:0] a_vpos;

    video_timing_gen #(
        .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b1), .X_SHIFT (1), .Y_SHIFT (1), .LAG (2), .ADDR_W (4)
    ) u_s1 (
        .i_clk (clk), .i_reset (reset), .i_pix_ce (ce_s1), .o_display_addr (a_addr),
        .o_hsync (a_hs), .o_vsync (a_vs), .o_display_on (a_den), .o_hpos (a_hpos),
        .o_vpos (a_vpos), .o_line_start (a_ls), .o_frame_start (a_fs)
    );

    logic [5:0] b_addr;
    logic       b_hs, b_vs, b_den, b_ls, b_fs;
    logic [3:0] b_hpos;
    logic [2:0] b_vpos;

    video_timing_gen #(
        .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
        .HSYNC_POL (1'b0), .VSYNC_POL (1'b0), .X_SHIFT (0), .Y_SHIFT (0), .LAG (1), .ADDR_W (6)
    ) u_s2 (
        .i_clk (clk), .i_reset (reset), .i_pix_ce (ce_s2), .o_display_addr (b_addr),
        .o_hsync (b_hs), .o_vsync (b_vs), .o_display_on (b_den), .o_hpos (b_hpos),
        .o_vpos (b_vpos), .o_line_start (b_ls), .o_frame_start (b_fs)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        n_checks++;
        assert (obs === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expected);
        end
    endtask

    // Expected {hs, vs, den, ls, fs, hpos[3:0], vpos[2:0]} of the 16x8 raster for output
    // index o (-1 = parked reset position, below that = reset values).
    function automatic logic [11:0] exp_out(input int o, input logic pol);
        int h;
        int v;
        if (o < -1) return {~pol, ~pol, 3'b000, 4'd0, 3'd0};
        if (o == -1) begin
            h = 15;
            v = 7;
        end else begin
            h = o % 16;
            v = (o / 16) % 8;
        end
        return {((h >= 10 && h <= 12) ? pol : ~pol), ((v >= 5 && v <= 6) ? pol : ~pol),
                (h < 8 && v < 4), (o >= 0 && h == 0), (o >= 0 && h == 0 && v == 0),
                4'(h), 3'(v)};
    endfunction

    // Expected stage-0 address for stage index s of the 16x8 raster with 2^sh replication.
    function automatic int exp_addr(input int s, input int sh);
        int h = s % 16;
        int v = (s / 16) % 8;
        int w = 8 >> sh;
        if (v >= 4) return (4 >> sh) * w;
        if (h < 8) return (v >> sh) * w + (h >> sh);
        return (v >> sh) * w + w;
    endfunction

    initial begin
        int hs_low;
        int first_hs;
        int den_cnt;
        int first_off;
        int p;
        logic [11:0] e;

        reset = 1'b1;
        ce_s1 = 1'b0;
        ce_s2 = 1'b0;
        repeat (2) tick();
        check("def_reset", {d_hs, d_vs, d_den, d_ls, d_fs, d_hpos, d_vpos}, {5'b11000, 20'd0});
        check("def_reset_addr", 32'(d_addr), 0);
        check("s1_reset_pol", {a_hs, a_vs, a_den, a_ls, a_fs, a_hpos, a_vpos}, exp_out(-2, 1'b1));
        check("s2_reset", {b_hs, b_vs, b_den, b_ls, b_fs, b_hpos, b_vpos}, exp_out(-2, 1'b0));
        reset = 1'b0;

        // Default timing: first edge shows the parked position, second shows (0,0)
        tick();
        check("def_p1", {d_hs, d_vs, d_den, d_ls, d_fs, d_hpos, d_vpos},
              {5'b11000, 10'd799, 10'd524});
        check("def_p1_addr", 32'(d_addr), 0);
        hs_low = 0;
        first_hs = -1;
        den_cnt = 0;
        first_off = -1;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (i == 0) begin
                check("def_first_pixel", {d_den, d_ls, d_fs, d_hpos, d_vpos}, {3'b111, 20'd0});
                check("def_addr_1", 32'(d_addr), 1);
            end
            if (i == 1) check("def_strobes_off", {d_ls, d_fs, d_hpos}, {2'b00, 10'd1});
            if (i == 638) check("def_addr_639", 32'(d_addr), 639);
            if (i == 639) check("def_addr_640", 32'(d_addr), 640);
            if (d_hs == 1'b0) begin
                hs_low++;
                if (first_hs < 0) first_hs = int'(d_hpos);
            end
            if (d_den) den_cnt++;
            else if (first_off < 0) first_off = int'(d_hpos);
        end
        check("def_hsync_width", 32'(hs_low), 96);
        check("def_hsync_start", 32'(first_hs), 656);
        check("def_den_count", 32'(den_cnt), 640);
        check("def_den_fall_hpos", 32'(first_off), 640);
        check("def_line1_base", 32'(d_addr), 640);

        // Mid-line reset at (300,1)
        repeat (301) tick();
        check("def_pre_reset_pos", {d_den, d_hpos, d_vpos}, {1'b1, 10'd300, 10'd1});
        reset = 1'b1;
        #1;
        check("def_reset_async", {d_hs, d_vs, d_den, d_ls, d_fs, d_hpos, d_vpos}, {5'b11000, 20'd0});
        check("def_reset_async_addr", 32'(d_addr), 0);
        tick();
        reset = 1'b0;
        tick();
        check("def_restart_p1", {d_den, d_fs, d_hpos, d_vpos}, {2'b00, 10'd799, 10'd524});
        check("def_restart_addr0", 32'(d_addr), 0);
        tick();
        check("def_restart_frame", {d_den, d_ls, d_fs, d_hpos, d_vpos}, {3'b111, 20'd0});
        check("def_restart_addr1", 32'(d_addr), 1);

        // 2x replicated raster, LAG=2, positive syncs
        reset = 1'b1;
        tick();
        ce_s1 = 1'b1;
        reset = 1'b0;
        for (p = 1; p <= 131; p++) begin
            tick();
            check($sformatf("s1_out_p%0d", p), {a_hs, a_vs, a_den, a_ls, a_fs, a_hpos, a_vpos},
                  exp_out(p - 3, 1'b1));
            check($sformatf("s1_addr_p%0d", p), 32'(a_addr), exp_addr(p - 1, 1));
        end
        ce_s1 = 1'b0;

        // Half-rate pixel enable: state holds on ce=0 clocks, strobes last one clk
        reset = 1'b1;
        tick();
        reset = 1'b0;
        p = 0;
        for (int c = 0; c < 264; c++) begin
            ce_s2 = (c % 2 == 0);
            tick();
            if (ce_s2) p++;
            e = exp_out(p - 2, 1'b0);
            if (!ce_s2) e[8:7] = 2'b00;
            check($sformatf("s2_out_c%0d", c), {b_hs, b_vs, b_den, b_ls, b_fs, b_hpos, b_vpos}, e);
            check($sformatf("s2_addr_c%0d", c), 32'(b_addr), exp_addr(p - 1, 0));
        end
        ce_s2 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
